// File: rtl/router_pkg.sv
// Router-wide shared definitions.
//   NUM_CH_DEFAULT  : default number of output channels/FIFOs
//   TIMEOUT_DEFAULT : default stalled cycles before a channel soft reset
//   CNT_W_DEFAULT   : default watchdog counter width
//   addr_legal()    : header address check, shared with the router FSM
package router_pkg;

    localparam int unsigned NUM_CH_DEFAULT  = 3;
    localparam int unsigned TIMEOUT_DEFAULT = 30;
    localparam int unsigned CNT_W_DEFAULT   = 5;

    // Widest header address field any router configuration uses (NUM_CH <= 16).
    localparam int unsigned ADDR_MAX_W = 8;

    // True when the header address names an existing channel.
    function automatic logic addr_legal(input logic [ADDR_MAX_W-1:0] addr,
                                        input int unsigned num_ch);
        return {{(32 - ADDR_MAX_W){1'b0}}, addr} < num_ch;
    endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// One channel's unread-data watchdog.
//   clock      : rising-edge clock
//   resetn     : synchronous active-low reset
//   vld        : channel FIFO holds data
//   rd         : destination is reading the channel this cycle
//   soft_reset : one-cycle FIFO soft reset after TIMEOUT consecutive stalls
module router_sync_wdog #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_reset_q, soft_reset_d;
    logic             stall;

    assign stall = vld & ~rd;

    // Any non-stalled cycle clears progress; the TIMEOUT-th stall fires and
    // restarts the count so a persistent stall pulses every TIMEOUT cycles.
    always_comb begin
        cnt_d        = '0;
        soft_reset_d = 1'b0;
        if (stall) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                soft_reset_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Router write-steering and per-channel watchdog.
//   clock, resetn  : rising-edge clock, synchronous active-low reset
//   detect_add     : header byte on addr_in this cycle
//   addr_in        : destination address from the header
//   write_enb_reg  : FSM write request for the current byte
//   read_enb       : per-channel read strobes from the destinations
//   empty, full    : per-FIFO status flags
//   write_enb      : one-hot write enable to the addressed FIFO
//   fifo_full      : full flag of the addressed FIFO
//   vld_out        : per-channel data available
//   soft_reset     : per-channel one-cycle FIFO soft reset
//   addr_err       : one-cycle pulse when the latched address has no channel
module router_sync_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = NUM_CH_DEFAULT,
    parameter int unsigned ADDR_W  = $clog2(NUM_CH),
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_vld_q;
    logic              addr_err_q;
    logic              addr_ok;

    assign addr_ok = addr_legal(ADDR_MAX_W'(addr_in), NUM_CH);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (detect_add) begin
            addr_q     <= addr_in;
            addr_vld_q <= 1'b1;
            addr_err_q <= ~addr_ok;
        end else begin
            addr_err_q <= 1'b0;
        end
    end

    assign addr_err = addr_err_q;

    // Only legal channel indices are matched, so an illegal latched address
    // leaves every enable low and reports not-full.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_wdog (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
module tb_router_sync_n;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    // Instance A: default configuration (NUM_CH=3, TIMEOUT=30).
    logic       a_detect_add, a_we_reg, a_fifo_full, a_addr_err;
    logic [1:0] a_addr_in;
    logic [2:0] a_read_enb, a_empty, a_full, a_write_enb, a_vld_out, a_soft_reset;

    router_sync_n u_dut_a (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (a_detect_add),
        .addr_in       (a_addr_in),
        .write_enb_reg (a_we_reg),
        .read_enb      (a_read_enb),
        .empty         (a_empty),
        .full          (a_full),
        .write_enb     (a_write_enb),
        .fifo_full     (a_fifo_full),
        .vld_out       (a_vld_out),
        .soft_reset    (a_soft_reset),
        .addr_err      (a_addr_err)
    );

    // Instance B: NUM_CH=4, TIMEOUT=5.
    logic       b_detect_add, b_we_reg, b_fifo_full, b_addr_err;
    logic [1:0] b_addr_in;
    logic [3:0] b_read_enb, b_empty, b_full, b_write_enb, b_vld_out, b_soft_reset;

    router_sync_n #(
        .NUM_CH  (4),
        .TIMEOUT (5)
    ) u_dut_b (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (b_detect_add),
        .addr_in       (b_addr_in),
        .write_enb_reg (b_we_reg),
        .read_enb      (b_read_enb),
        .empty         (b_empty),
        .full          (b_full),
        .write_enb     (b_write_enb),
        .fifo_full     (b_fifo_full),
        .vld_out       (b_vld_out),
        .soft_reset    (b_soft_reset),
        .addr_err      (b_addr_err)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // Reset with a header present: reset must win.
        resetn       = 1'b0;
        a_detect_add = 1'b1; a_addr_in = 2'd1; a_we_reg = 1'b1;
        a_read_enb   = 3'b000; a_empty = 3'b111; a_full = 3'b111;
        b_detect_add = 1'b0; b_addr_in = 2'd0; b_we_reg = 1'b0;
        b_read_enb   = 4'b0000; b_empty = 4'b1111; b_full = 4'b0000;
        tick(2);
        check("rst_write_enb", 16'(a_write_enb), 16'h0);
        check("rst_fifo_full", 16'(a_fifo_full), 16'h0);
        check("rst_soft_reset", 16'(a_soft_reset), 16'h0);
        check("rst_addr_err", 16'(a_addr_err), 16'h0);
        resetn       = 1'b1;
        a_detect_add = 1'b0;
        tick(1);
        check("post_rst_write_enb", 16'(a_write_enb), 16'h0);
        check("post_rst_fifo_full", 16'(a_fifo_full), 16'h0);

        // Steering to channel 2.
        a_detect_add = 1'b1; a_addr_in = 2'd2; a_we_reg = 1'b0; a_full = 3'b100;
        tick(1);
        a_detect_add = 1'b0; a_we_reg = 1'b1;
        #1;
        check("legal_addr_err", 16'(a_addr_err), 16'h0);
        check("steer2_write_enb", 16'(a_write_enb), 16'h4);
        check("steer2_fifo_full", 16'(a_fifo_full), 16'h1);

        // New header in the same cycle as a write still uses the old address.
        a_detect_add = 1'b1; a_addr_in = 2'd0;
        #1;
        check("same_cycle_old_addr", 16'(a_write_enb), 16'h4);
        tick(1);
        a_detect_add = 1'b0;
        #1;
        check("steer0_write_enb", 16'(a_write_enb), 16'h1);
        check("steer0_fifo_full_lo", 16'(a_fifo_full), 16'h0);
        a_full = 3'b001;
        #1;
        check("steer0_fifo_full_hi", 16'(a_fifo_full), 16'h1);
        a_we_reg = 1'b0;
        #1;
        check("steer0_we_reg_lo", 16'(a_write_enb), 16'h0);

        // Illegal address.
        a_detect_add = 1'b1; a_addr_in = 2'd3;
        tick(1);
        a_detect_add = 1'b0; a_we_reg = 1'b1; a_full = 3'b111;
        #1;
        check("illegal_addr_err", 16'(a_addr_err), 16'h1);
        check("illegal_write_enb", 16'(a_write_enb), 16'h0);
        check("illegal_fifo_full", 16'(a_fifo_full), 16'h0);
        tick(1);
        check("illegal_addr_err_drop", 16'(a_addr_err), 16'h0);
        a_we_reg = 1'b0;

        // vld_out mirrors ~empty (reads asserted so nothing stalls).
        a_read_enb = 3'b111; a_empty = 3'b010;
        #1;
        check("vld_out_101", 16'(a_vld_out), 16'h5);
        a_empty = 3'b111; a_read_enb = 3'b000;
        tick(1);

        // Persistent stall on channel 1: pulses after 30 and 60 stall edges.
        a_empty = 3'b101;
        for (int k = 1; k <= 61; k++) begin
            tick(1);
            check($sformatf("timeout_cyc%0d", k), 16'(a_soft_reset),
                  (k == 30 || k == 60) ? 16'h2 : 16'h0);
        end
        a_empty = 3'b111;
        tick(1);

        // 29 stalls, one read clears, then a full 30 more are needed.
        a_empty = 3'b101;
        tick(29);
        check("clear_pre_read", 16'(a_soft_reset), 16'h0);
        a_read_enb = 3'b010;
        tick(1);
        check("clear_read_cycle", 16'(a_soft_reset), 16'h0);
        a_read_enb = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            tick(1);
            check($sformatf("clear_cyc%0d", k), 16'(a_soft_reset), (k == 30) ? 16'h2 : 16'h0);
        end
        a_empty = 3'b111;

        // Reset mid-count discards progress.
        a_empty = 3'b101;
        tick(20);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 10 || k >= 29) begin
                check($sformatf("rst_mid_cyc%0d", k), 16'(a_soft_reset),
                      (k == 30) ? 16'h2 : 16'h0);
            end
        end
        a_empty = 3'b111;

        // Four-channel instance: address 3 is legal.
        b_detect_add = 1'b1; b_addr_in = 2'd3;
        tick(1);
        b_detect_add = 1'b0; b_we_reg = 1'b1; b_full = 4'b1000;
        #1;
        check("b_addr_err", 16'(b_addr_err), 16'h0);
        check("b_write_enb", 16'(b_write_enb), 16'h8);
        check("b_fifo_full", 16'(b_fifo_full), 16'h1);
        b_we_reg = 1'b0;

        // All four channels stall together with TIMEOUT=5.
        b_empty = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check($sformatf("b_timeout_cyc%0d", k), 16'(b_soft_reset),
                  (k == 5) ? 16'hF : 16'h0);
        end
        check("a_quiet_during_b", 16'(a_soft_reset), 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised write-steering and watchdog block for the router, sitting between the router FSM/register stage and NUM_CH output FIFOs. It latches the destination address from the header byte and steers the FSM's write enable to one FIFO. It reports the selected FIFO's full flag, drives per-channel valid-out from FIFO empty flags, and soft-resets any channel whose valid data goes unread for TIMEOUT consecutive cycles.

## Interface
Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, $clog2(NUM_CH), width of header address field
- TIMEOUT, 30, consecutive stalled cycles before soft reset (2..2^CNT_W-1)
- CNT_W, 5, watchdog counter width

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- detect_add  in  1  header byte present on addr_in this cycle
- addr_in  in  ADDR_W  destination address (header bits [ADDR_W-1:0])
- write_enb_reg  in  1  FSM write request for current byte
- read_enb  in  NUM_CH  per-channel read strobe from destination
- empty  in  NUM_CH  per-FIFO empty flag
- full  in  NUM_CH  per-FIFO full flag
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of the selected FIFO
- vld_out  out  NUM_CH  per-channel data-available
- soft_reset  out  NUM_CH  one-cycle per-channel FIFO soft reset
- addr_err  out  1  one-cycle pulse: latched address >= NUM_CH

## Operation
- Address latch: on clock edge with detect_add=1, addr_q <= addr_in, addr_vld <= 1. addr_q holds until next detect_add. addr_err <= (addr_in >= NUM_CH) on that edge, else 0.
- Steering (combinational from addr_q): write_enb[i] = write_enb_reg & addr_vld & (addr_q == i); fifo_full = addr_vld & (addr_q < NUM_CH) & full[addr_q]. Illegal address: write_enb all 0, fifo_full 0.
- vld_out = ~empty, combinational.
- Watchdog per channel i, counter cnt[i]:
  - stall = vld_out[i] & ~read_enb[i].
  - stall=0 -> cnt <= 0, soft_reset <= 0.
  - stall=1, cnt < TIMEOUT-1 -> cnt <= cnt+1, soft_reset <= 0.
  - stall=1, cnt == TIMEOUT-1 -> cnt <= 0, soft_reset <= 1 (one cycle).
  - Channels independent; simultaneous soft resets allowed.
- Reset (resetn=0 at edge): addr_q=0, addr_vld=0, addr_err=0, all cnt=0, soft_reset=0. Hence write_enb=0, fifo_full=0 after reset until first detect_add. Reset overrides detect_add in the same cycle. Reset mid-count discards progress.

## Timing
- Address latency: 1 cycle; write_enb/fifo_full follow new address from cycle after detect_add. detect_add and write_enb_reg in same cycle steer with previous addr_q (the header write by the FSM follows detect_add by ≥1 cycle).
- write_enb, fifo_full, vld_out: zero-latency combinational from registered/input state.
- soft_reset: high in the cycle after the TIMEOUT-th consecutive stall edge, for exactly one cycle. Continued stall restarts the count, giving the next pulse TIMEOUT cycles later.
- A read_enb or empty pulse at any point clears the count; a stall at cnt==TIMEOUT-1 still fires regardless of prior history.
- addr_err: registered, valid one cycle after detect_add.

## Structure
- Package router_pkg: NUM_CH_DEFAULT, TIMEOUT_DEFAULT, CNT_W_DEFAULT, and the addr_legal(addr) check function shared with router FSM.
- Sub-module router_sync_wdog: one channel's counter plus soft_reset register (params TIMEOUT, CNT_W; ports clock, resetn, vld, rd, soft_reset). Instantiated NUM_CH times by generate loop.
- Top holds the address latch, steering, and addr_err logic.

## Test plan
- Reset: hold resetn=0 with detect_add=1, addr_in=1 -> write_enb=000, fifo_full=0, soft_reset=000, addr_err=0 after release.
- Steering: detect_add with addr_in=2, then write_enb_reg=1, full=100 -> write_enb=100, fifo_full=1; switch to addr_in=0 -> write_enb=001, fifo_full=full[0].
- Illegal address: detect_add with addr_in=3 (NUM_CH=3) -> addr_err pulses 1 cycle; write_enb=000 and fifo_full=0 even with write_enb_reg=1, full=111.
- Timeout: empty[1]=0, read_enb[1]=0 held 30 cycles -> soft_reset[1]=1 on cycle 31 only; held 60 cycles -> second pulse on cycle 61; channels 0 and 2 stay 0.
- Count clear: stall 29 cycles, read_enb[1]=1 for one cycle, stall again -> no pulse until 30 further stall cycles.
- Parametrised: NUM_CH=4, TIMEOUT=5, all channels stalled -> soft_reset=1111 together on cycle 6; addr_in=3 -> write_enb=1000, addr_err=0.
